cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Round-robin arbiter and driver for the common data bus (CDB).
- Sits between the functional-unit state controllers (add ALU, mul/div ALU, load unit, and similar) and the reservation stations and register status.
- Each unit raises `require` when its result is ready. The arbiter returns a one-cycle `requireAC` to exactly one unit and registers that unit's label and result onto the CDB on the same edge.
- A unit's controller treats `require && requireAC` as "result taken, may accept next op".

Parameters:
- N_REQ, 4, number of requesting functional units (2..8).
- DATA_W, 32, result width.
- LABEL_W, 4, reservation-station label width; label 0 = "no producer".

Ports:
- clk  in  1  clock.
- nRST  in  1  reset, synchronous, active-low.
- require  in  N_REQ  per-unit CDB request; held high until acknowledged.
- labelIn  in  N_REQ*LABEL_W  per-unit label; unit k at bits [k*LABEL_W +: LABEL_W].
- resultIn  in  N_REQ*DATA_W  per-unit result; unit k at bits [k*DATA_W +: DATA_W].
- stall  in  1  1 = suppress all grants this cycle.
- requireAC  out  N_REQ  combinational one-hot grant; at most one bit set.
- cdbValid  out  1  registered: CDB carries a valid broadcast this cycle.
- cdbLabel  out  LABEL_W  registered broadcast label; 0 when cdbValid=0.
- cdbData  out  DATA_W  registered broadcast data; 0 when cdbValid=0.
- grantIdx  out  clog2(N_REQ)  registered index of the last granted unit (debug).

Behaviour:
- Reset (nRST=0 at posedge clk):
  - rr_ptr<=0, cdbValid<=0, cdbLabel<=0, cdbData<=0, grantIdx<=0.
  - requireAC is forced to 0 combinationally while nRST=0.
  - Reset mid-transfer drops any pending broadcast; requesters keep `require` and are re-served after reset.
- Grant selection (combinational):
  - Scan units rr_ptr, rr_ptr+1, …, wrapping modulo N_REQ.
  - The first unit with require=1 gets requireAC=1.
  - If stall=1 or no require is set, requireAC=0.
- On posedge clk with a grant to unit g:
  - cdbValid<=1, cdbLabel<=labelIn[g], cdbData<=resultIn[g], grantIdx<=g.
  - rr_ptr<=(g+1) mod N_REQ.
- On posedge clk with no grant:
  - cdbValid<=0, cdbLabel<=0, cdbData<=0.
  - rr_ptr and grantIdx hold.
- Latency: the broadcast appears on the CDB 1 cycle after the acknowledge cycle. Data is sampled in the acknowledge cycle, so the unit may change its outputs afterwards.
- Throughput: one broadcast per cycle. Back-to-back grants to different units are allowed.
- Back-to-back grants to the same unit are allowed only if it is the sole requester.
- Fairness: with all N_REQ units requesting continuously, each is granted exactly once every N_REQ cycles.
- Wrap-around: rr_ptr = N_REQ-1 with a grant to unit N_REQ-1 gives rr_ptr = 0.
- stall:
  - Blocks grants only. It does not change rr_ptr.
  - The broadcast already registered from the previous cycle is still presented.
- A request deasserted before acknowledge is simply not served; no state is retained per requester.
- A requester presenting labelIn=0 is still granted and broadcast as given (not filtered).

Test Plan:
- Reset then idle:
  - Stimulus: nRST=0 for 2 cycles, require=0000.
  - Required: requireAC=0000 and cdbValid=0, cdbLabel=0, cdbData=0 every cycle.
- Single requester:
  - Stimulus: unit 1 with label=5, result=0x0000_0064, held until ack.
  - Required: requireAC=0010 in cycle T; next cycle cdbValid=1, cdbLabel=5, cdbData=0x64, grantIdx=1.
- Round-robin rotation:
  - Stimulus: require=1111 held 8 cycles from reset.
  - Required: grant order 0,1,2,3,0,1,2,3; exactly one hot bit each cycle.
- Pointer skip/wrap:
  - Stimulus: rr_ptr=3 (after a grant to unit 2); require=0011.
  - Required: grant unit 0, then unit 1; rr_ptr goes to 1, then 2.
- Stall:
  - Stimulus: stall=1 for 3 cycles with require=0100.
  - Required: requireAC=0 during stall; cdbValid=0 from the 2nd stall cycle.
  - After stall drops: unit 2 granted the same cycle; broadcast the following cycle.
- Reset mid-operation:
  - Stimulus: grant unit 3 at T; nRST=0 at T+1.
  - Required: cdbValid=0 and rr_ptr=0 after the edge.
  - With require=1000 still high after reset release: unit 3 granted again.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter driving the common data bus: grants one requesting
// functional unit per cycle and registers its label/result as the broadcast.
module cdb_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 32,
    parameter int LABEL_W = 4
) (
    input  logic                         clk,
    input  logic                         nRST,
    input  logic [N_REQ-1:0]             require,
    input  logic [N_REQ*LABEL_W-1:0]     labelIn,
    input  logic [N_REQ*DATA_W-1:0]      resultIn,
    input  logic                         stall,
    output logic [N_REQ-1:0]             requireAC,
    output logic                         cdbValid,
    output logic [LABEL_W-1:0]           cdbLabel,
    output logic [DATA_W-1:0]            cdbData,
    output logic [$clog2(N_REQ)-1:0]     grantIdx
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
    logic               cdb_valid_q, cdb_valid_d;
    logic [LABEL_W-1:0] cdb_label_q, cdb_label_d;
    logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;

    logic [IDX_W-1:0]   sel_idx;
    logic               sel_found;
    logic               grant;
    logic [IDX_W:0]     cand;
    logic [LABEL_W-1:0] sel_label;
    logic [DATA_W-1:0]  sel_data;

    // Scan from rr_ptr upward, wrapping modulo N_REQ, for the first requester.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(N_REQ))
                cand = cand - (IDX_W+1)'(N_REQ);
            if (!sel_found && require[cand[IDX_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IDX_W-1:0];
            end
        end
    end

    assign grant = nRST && !stall && sel_found;

    always_comb begin
        requireAC = '0;
        sel_label = '0;
        sel_data  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (IDX_W'(k) == sel_idx) begin
                sel_label = labelIn[k*LABEL_W +: LABEL_W];
                sel_data  = resultIn[k*DATA_W +: DATA_W];
                if (grant)
                    requireAC[k] = 1'b1;
            end
        end
    end

    // Next broadcast: captured in the acknowledge cycle, presented the cycle after.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        cdb_valid_d = 1'b0;
        cdb_label_d = '0;
        cdb_data_d  = '0;
        if (grant) begin
            cdb_valid_d = 1'b1;
            cdb_label_d = sel_label;
            cdb_data_d  = sel_data;
            grant_idx_d = sel_idx;
            rr_ptr_d    = (sel_idx == IDX_W'(N_REQ-1)) ? '0 : sel_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            cdb_valid_q <= 1'b0;
            cdb_label_q <= '0;
            cdb_data_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_label_q <= cdb_label_d;
            cdb_data_q  <= cdb_data_d;
        end
    end

    assign cdbValid = cdb_valid_q;
    assign cdbLabel = cdb_label_q;
    assign cdbData  = cdb_data_q;
    assign grantIdx = grant_idx_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed and random requests against a round-robin
// reference model, with expectations queued and checked by a separate monitor.
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int LW = 4;
    localparam int IW = $clog2(N);

    logic              clk;
    logic              nRST;
    logic [N-1:0]      require;
    logic [N*LW-1:0]   labelIn;
    logic [N*DW-1:0]   resultIn;
    logic              stall;
    logic [N-1:0]      requireAC;
    logic              cdbValid;
    logic [LW-1:0]     cdbLabel;
    logic [DW-1:0]     cdbData;
    logic [IW-1:0]     grantIdx;

    cdb_arbiter #(.N_REQ(N), .DATA_W(DW), .LABEL_W(LW)) dut (
        .clk(clk), .nRST(nRST), .require(require), .labelIn(labelIn),
        .resultIn(resultIn), .stall(stall), .requireAC(requireAC),
        .cdbValid(cdbValid), .cdbLabel(cdbLabel), .cdbData(cdbData),
        .grantIdx(grantIdx)
    );

    typedef struct {
        int           c;
        logic [N-1:0] ack;
    } ack_t;

    typedef struct {
        int            c;
        logic          v;
        logic [LW-1:0] l;
        logic [DW-1:0] d;
        logic [IW-1:0] i;
    } cdb_t;

    ack_t ackq[$];
    cdb_t cdbq[$];
    ack_t am;
    cdb_t cm;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ptr_m = 0;
    int gidx_m = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: the arbiter as a rotating priority over unit numbers.
    task automatic step(input logic r, input logic [N-1:0] req, input logic stl, input logic fix);
        int   g;
        int   u;
        ack_t a;
        cdb_t e;
        @(posedge clk);
        #1;
        nRST    = r;
        require = req;
        stall   = stl;
        for (int k = 0; k < N; k++) begin
            labelIn[k*LW +: LW]  = LW'($urandom);
            resultIn[k*DW +: DW] = $urandom;
        end
        if (fix) begin
            labelIn[LW +: LW]  = 4'd5;
            resultIn[DW +: DW] = 32'h0000_0064;
        end
        g = -1;
        if (r && !stl) begin
            for (int i = 0; i < N; i++) begin
                u = (ptr_m + i) % N;
                if (g < 0 && req[u]) g = u;
            end
        end
        a.c   = cyc;
        a.ack = '0;
        if (g >= 0) a.ack[g] = 1'b1;
        ackq.push_back(a);
        e.c = cyc + 1;
        if (!r) begin
            ptr_m = 0; gidx_m = 0;
            e.v = 1'b0; e.l = '0; e.d = '0;
        end else if (g >= 0) begin
            e.v = 1'b1;
            e.l = labelIn[g*LW +: LW];
            e.d = resultIn[g*DW +: DW];
            gidx_m = g;
            ptr_m  = (g + 1) % N;
        end else begin
            e.v = 1'b0; e.l = '0; e.d = '0;
        end
        e.i = IW'(gidx_m);
        cdbq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (ackq.size() > 0 && ackq[0].c == cyc) begin
            am = ackq.pop_front();
            chk("requireAC", 64'(requireAC), 64'(am.ack));
            chk("onehot", 64'($countones(requireAC) <= 1), 64'(1));
        end
        if (cdbq.size() > 0 && cdbq[0].c == cyc) begin
            cm = cdbq.pop_front();
            chk("cdbValid", 64'(cdbValid), 64'(cm.v));
            chk("cdbLabel", 64'(cdbLabel), 64'(cm.l));
            chk("cdbData",  64'(cdbData),  64'(cm.d));
            chk("grantIdx", 64'(grantIdx), 64'(cm.i));
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout @cyc %0d: got running want finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        nRST = 1'b0; require = '0; stall = 1'b0; labelIn = '0; resultIn = '0;
        // reset then idle
        step(0, 4'b0000, 0, 0);
        step(0, 4'b0000, 0, 0);
        step(1, 4'b0000, 0, 0);
        step(1, 4'b0000, 0, 0);
        // single requester, label 5 / result 0x64
        step(1, 4'b0010, 0, 1);
        step(1, 4'b0000, 0, 0);
        // rotation from reset
        step(0, 4'b0000, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 4'b1111, 0, 0);
        // pointer to 3 via grant to unit 2, then wrap to 0 and 1
        step(1, 4'b0100, 0, 0);
        step(1, 4'b0011, 0, 0);
        step(1, 4'b0011, 0, 0);
        step(1, 4'b0011, 0, 0);
        // stall with unit 2 waiting
        step(1, 4'b0100, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 4'b0100, 1, 0);
        step(1, 4'b0100, 0, 0);
        step(1, 4'b0000, 0, 0);
        // reset right after a grant to unit 3
        step(1, 4'b1000, 0, 0);
        step(0, 4'b1000, 0, 0);
        step(1, 4'b1000, 0, 0);
        step(1, 4'b0000, 0, 0);
        // sole requester back-to-back
        step(1, 4'b0001, 0, 0);
        step(1, 4'b0001, 0, 0);
        // random traffic
        for (int i = 0; i < 400; i++)
            step(($urandom % 40) != 0, N'($urandom), ($urandom % 6) == 0, 0);
        step(1, 4'b0000, 0, 0);
        step(1, 4'b0000, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("drain", 64'(ackq.size() + cdbq.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
